// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits are served combinationally in IDLE; misses write back a dirty victim, refill the line, then retry.
module l1_dcache_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    mem_stall,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_ack
);

  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - WSEL_W - 2;
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL} state_t;

  state_t                r_state;
  logic [NUM_LINES-1:0]  r_valid;
  logic [NUM_LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]      r_tag  [NUM_LINES];
  logic [DATA_WIDTH-1:0] r_data [NUM_LINES*LINE_WORDS];
  logic [WSEL_W-1:0]     r_beat;
  logic [TAG_W-1:0]      r_miss_tag;
  logic [IDX_W-1:0]      r_miss_idx;

  logic [WSEL_W-1:0]       w_wsel;
  logic [IDX_W-1:0]        w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit;
  logic                    w_last_beat;
  logic [IDX_W+WSEL_W-1:0] w_cpu_word;
  logic [IDX_W+WSEL_W-1:0] w_bus_word;
  logic                    w_store_hit;
  logic                    w_refill_beat;

  assign w_wsel        = cpu_addr[2 +: WSEL_W];
  assign w_idx         = cpu_addr[2+WSEL_W +: IDX_W];
  assign w_tag         = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_last_beat   = (r_beat == WSEL_W'(LINE_WORDS-1));
  assign w_cpu_word    = {w_idx, w_wsel};
  assign w_bus_word    = {r_miss_idx, r_beat};
  assign w_store_hit   = (r_state == S_IDLE) && cpu_req && cpu_we && w_hit;
  assign w_refill_beat = (r_state == S_REFILL) && bus_ack;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    mem_stall = 1'b0;
    cpu_rdata = '0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (r_state)
      S_IDLE: begin
        mem_stall = cpu_req && !w_hit;
        if (cpu_req && w_hit && !cpu_we) cpu_rdata = r_data[w_cpu_word];
      end
      S_WRITEBACK: begin
        mem_stall = 1'b1;
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {r_tag[r_miss_idx], r_miss_idx, r_beat, 2'b00};
        bus_wdata = r_data[w_bus_word];
      end
      S_REFILL: begin
        mem_stall = 1'b1;
        bus_req   = 1'b1;
        bus_addr  = {r_miss_tag, r_miss_idx, r_beat, 2'b00};
      end
      default: mem_stall = 1'b1;
    endcase
  end

  // NOTE: tag and data arrays are deliberately not reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_store_hit) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (cpu_wstrb[b]) r_data[w_cpu_word][8*b +: 8] <= cpu_wdata[8*b +: 8];
        end
      end
      if (w_refill_beat) begin
        r_data[w_bus_word] <= bus_rdata;
        if (w_last_beat) r_tag[r_miss_idx] <= r_miss_tag;
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_beat     <= '0;
      r_miss_tag <= '0;
      r_miss_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            if (w_hit) begin
              if (cpu_we) r_dirty[w_idx] <= 1'b1;
            end else begin
              r_miss_tag     <= w_tag;
              r_miss_idx     <= w_idx;
              r_beat         <= '0;
              // The line is invalid while being replaced so an aborted fill never leaves it valid.
              r_valid[w_idx] <= 1'b0;
              r_state        <= (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_REFILL;
            end
          end
        end
        S_WRITEBACK: begin
          if (bus_ack) begin
            r_beat <= r_beat + WSEL_W'(1);
            if (w_last_beat) begin
              r_beat  <= '0;
              r_state <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (bus_ack) begin
            r_beat <= r_beat + WSEL_W'(1);
            if (w_last_beat) begin
              r_beat              <= '0;
              r_valid[r_miss_idx] <= 1'b1;
              r_dirty[r_miss_idx] <= 1'b0;
              r_state             <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Self-checking bench for l1_dcache_ctrl: table-driven accesses against a behavioural bus memory,
// plus hand-written sequences for slow acks, a dropped request and a reset mid-writeback.
module tb_l1_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic [31:0] cpu_rdata;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  l1_dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_rdata(cpu_rdata),
    .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [3:0]      strb;
    logic [31:0]     exp_rdata;
    int              exp_stalls;
    int              n_wb;
    logic [31:0]     wb_base;
    logic [3:0][31:0] wb_data;
    int              n_rf;
    logic [31:0]     rf_base;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ack_period = 1;
  int wait_cnt = 0;
  int unstable_cnt = 0;
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  logic        prev_we = 1'b0;
  beat_t beats[$];
  logic [31:0] mem[logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Bus responder: decides ack for the coming edge, logs acked beats, watches address stability.
  always @(negedge clk) begin
    if (bus_req) begin
      if (prev_pending && (bus_addr != prev_addr || bus_we != prev_we ||
                           (bus_we && bus_wdata != prev_wdata)))
        unstable_cnt++;
      bus_rdata = mem_rd(bus_addr);
      if (wait_cnt == ack_period - 1) begin
        bus_ack = 1'b1;
        wait_cnt = 0;
        prev_pending = 1'b0;
        beats.push_back('{bus_we, bus_addr, bus_wdata});
        if (bus_we) mem[bus_addr] = bus_wdata;
      end else begin
        bus_ack = 1'b0;
        wait_cnt++;
        prev_pending = 1'b1;
        prev_addr = bus_addr;
        prev_we = bus_we;
        prev_wdata = bus_wdata;
      end
    end else begin
      bus_ack = 1'b0;
      wait_cnt = 0;
      prev_pending = 1'b0;
    end
  end

  // Holds one request until it completes; returns the unstalled read data and the stall count.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output int stalls);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = strb;
    stalls = 0;
    rdata = '0;
    while (stalls < 200) begin
      @(negedge clk); #1;
      if (!mem_stall) break;
      stalls++;
      @(posedge clk); #1;
    end
    rdata = cpu_rdata;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  vec_t vecs[9];
  logic [31:0] rd;
  int st;

  initial begin
    mem[32'h100]  = 32'hA0; mem[32'h104]  = 32'hA1; mem[32'h108]  = 32'hA2; mem[32'h10C]  = 32'hA3;
    mem[32'h1100] = 32'hB0; mem[32'h1104] = 32'hB1; mem[32'h1108] = 32'hB2; mem[32'h110C] = 32'hB3;

    vecs[0] = '{1'b0, 32'h100,  32'h0, 4'h0, 32'hA0,       5, 0, 32'h0,   '0, 4, 32'h100};
    vecs[1] = '{1'b1, 32'h104,  32'hDEADBEEF, 4'b0011, 32'h0, 0, 0, 32'h0, '0, 0, 32'h0};
    vecs[2] = '{1'b0, 32'h104,  32'h0, 4'h0, 32'h0000BEEF, 0, 0, 32'h0,   '0, 0, 32'h0};
    vecs[3] = '{1'b0, 32'h1104, 32'h0, 4'h0, 32'hB1,       9, 4, 32'h100,
                {32'hA3, 32'hA2, 32'h0000BEEF, 32'hA0}, 4, 32'h1100};
    vecs[4] = '{1'b0, 32'h10C,  32'h0, 4'h0, 32'hA3,       5, 0, 32'h0,   '0, 4, 32'h100};
    vecs[5] = '{1'b0, 32'h104,  32'h0, 4'h0, 32'h0000BEEF, 0, 0, 32'h0,   '0, 0, 32'h0};
    vecs[6] = '{1'b0, 32'h2008, 32'h0, 4'h0, 32'hC0DE2008, 5, 0, 32'h0,   '0, 4, 32'h2000};
    vecs[7] = '{1'b1, 32'h2008, 32'h11223344, 4'b1100, 32'h0, 0, 0, 32'h0, '0, 0, 32'h0};
    vecs[8] = '{1'b0, 32'h2008, 32'h0, 4'h0, 32'h11222008, 0, 0, 32'h0,   '0, 0, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("reset bus_req", {31'b0, bus_req}, 32'h0);
    check("reset mem_stall", {31'b0, mem_stall}, 32'h0);
    check("reset cpu_rdata", cpu_rdata, 32'h0);

    // Table-driven accesses
    foreach (vecs[i]) begin
      beats.delete();
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, st);
      check($sformatf("v%0d stalls", i), st, vecs[i].exp_stalls);
      if (!vecs[i].we) check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d beats", i), beats.size(), vecs[i].n_wb + vecs[i].n_rf);
      if (beats.size() == vecs[i].n_wb + vecs[i].n_rf) begin
        for (int j = 0; j < vecs[i].n_wb; j++) begin
          check($sformatf("v%0d wb%0d we", i, j), {31'b0, beats[j].we}, 32'h1);
          check($sformatf("v%0d wb%0d addr", i, j), beats[j].addr, vecs[i].wb_base + 32'(4*j));
          check($sformatf("v%0d wb%0d data", i, j), beats[j].data, vecs[i].wb_data[j]);
        end
        for (int j = 0; j < vecs[i].n_rf; j++) begin
          check($sformatf("v%0d rf%0d we", i, j), {31'b0, beats[vecs[i].n_wb+j].we}, 32'h0);
          check($sformatf("v%0d rf%0d addr", i, j), beats[vecs[i].n_wb+j].addr,
                vecs[i].rf_base + 32'(4*j));
        end
      end
    end

    // Slow bus: ack every 3rd cycle, dirty victim at index 0 (line 0x2000)
    ack_period = 3;
    unstable_cnt = 0;
    beats.delete();
    access(1'b0, 32'h3004, 32'h0, 4'h0, rd, st);
    check("slow stalls", st, 25);
    check("slow rdata", rd, 32'hC0DE3004);
    check("slow beats", beats.size(), 8);
    check("slow addr stable", unstable_cnt, 0);
    if (beats.size() == 8) begin
      check("slow wb2 data", beats[2].data, 32'h11222008);
      check("slow rf0 addr", beats[4].addr, 32'h3000);
    end
    ack_period = 1;

    // Request dropped after the first refill beat: the fill still completes
    beats.delete();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4010;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (beats.size() >= 1) break;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (!bus_req) break;
    end
    check("drop beats", beats.size(), 4);
    if (beats.size() == 4) check("drop last addr", beats[3].addr, 32'h401C);
    access(1'b0, 32'h4018, 32'h0, 4'h0, rd, st);
    check("drop hit stalls", st, 0);
    check("drop hit rdata", rd, 32'hC0DE4018);

    // Reset during beat 2 of a writeback
    access(1'b1, 32'h401C, 32'h55667788, 4'b1111, rd, st);
    check("pre-rst store stalls", st, 0);
    beats.delete();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h8010;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #1;
      if (beats.size() >= 2) break;
    end
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk); #1;
    check("mid-wb bus_we", {31'b0, bus_we}, 32'h1);
    check("mid-wb bus_addr", bus_addr, 32'h4018);
    @(negedge clk); #1;
    check("rst bus_req", {31'b0, bus_req}, 32'h0);
    check("rst mem_stall", {31'b0, mem_stall}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    access(1'b0, 32'h401C, 32'h0, 4'h0, rd, st);
    check("post-rst stalls", st, 5);
    check("post-rst rdata", rd, 32'hC0DE401C);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
